// File: rtl/ama_riscv_defines.sv
// Shared frontend-control types: pc select, fetch control bundle, FSM states
// and the per-stage stall/bubble bundle.
package ama_riscv_defines;

  typedef enum logic [1:0] {
    PC_SEL_INC4 = 2'd0,
    PC_SEL_ALU  = 2'd1,
    PC_SEL_BP   = 2'd2,
    PC_SEL_RSVD = 2'd3
  } pc_sel_t;

  typedef logic [4:0] rf_addr_t;

  typedef struct packed {
    pc_sel_t pc_sel;
    logic    pc_we;
  } fe_ctrl_t;

  localparam fe_ctrl_t FE_CTRL_RST_VAL = '{pc_sel: PC_SEL_INC4, pc_we: 1'b0};

  typedef enum logic {
    FE_RUN,
    FE_CF_WAIT
  } fe_state_t;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic bubble_id;
    logic bubble_ex;
  } fe_stall_t;

  // ID reads a register that the load currently in EX has not produced yet
  function automatic logic load_use_hazard(input logic     dec_valid,
                                           input logic     ex_load,
                                           input logic     ex_rd_we,
                                           input rf_addr_t ex_rd_addr,
                                           input logic     uses_rs1,
                                           input rf_addr_t rs1_addr,
                                           input logic     uses_rs2,
                                           input rf_addr_t rs2_addr);
    return dec_valid & ex_load & ex_rd_we &
           ((uses_rs1 & (rs1_addr == ex_rd_addr)) | (uses_rs2 & (rs2_addr == ex_rd_addr)));
  endfunction

endpackage

// File: rtl/ama_riscv_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module ama_riscv_sat_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ama_riscv_fe_ctrl.sv
// Frontend sequencing: overrides the decoder's fetch request for dmem freezes,
// control-flow resolution, load-use hazards and imem back-pressure.
module ama_riscv_fe_ctrl
  import ama_riscv_defines::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  fe_ctrl_t         dec_fe_req,
  input  logic             dec_branch,
  input  logic             dec_jump,
  input  rf_addr_t         dec_rs1_addr,
  input  rf_addr_t         dec_rs2_addr,
  input  logic             dec_uses_rs1,
  input  logic             dec_uses_rs2,
  input  logic             ex_load,
  input  logic             ex_rd_we,
  input  rf_addr_t         ex_rd_addr,
  input  logic             ex_cf_valid,
  input  logic             ex_br_taken,
  input  logic             ex_jump,
  input  logic             imem_ready,
  input  logic             dmem_busy,
  output fe_ctrl_t         fe_ctrl,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             bubble_id,
  output logic             bubble_ex,
  output logic             cf_pending,
  output logic [CNT_W-1:0] cnt_cf,
  output logic [CNT_W-1:0] cnt_lu,
  output logic [CNT_W-1:0] cnt_imem
);

  fe_state_t state_q, state_d;
  fe_stall_t stall;
  logic      lu_hazard;
  logic      inc_cf, inc_lu, inc_imem;

  assign lu_hazard = load_use_hazard(dec_valid, ex_load, ex_rd_we, ex_rd_addr,
                                     dec_uses_rs1, dec_rs1_addr, dec_uses_rs2, dec_rs2_addr);

  always_comb begin
    state_d  = state_q;
    fe_ctrl  = FE_CTRL_RST_VAL;
    stall    = '0;
    inc_cf   = 1'b0;
    inc_lu   = 1'b0;
    inc_imem = 1'b0;
    if (rst) begin
      state_d         = FE_RUN;
      stall.bubble_id = 1'b1;
      stall.bubble_ex = 1'b1;
    end else if (dmem_busy) begin
      stall.stall_if = 1'b1;
      stall.stall_id = 1'b1;
      stall.stall_ex = 1'b1;
    end else if (state_q == FE_CF_WAIT) begin
      // Both the waiting and the resolving cycle count as redirect penalty
      inc_cf          = 1'b1;
      stall.bubble_id = 1'b1;
      if (ex_cf_valid) begin
        fe_ctrl.pc_sel = (ex_jump || ex_br_taken) ? PC_SEL_ALU : PC_SEL_INC4;
        fe_ctrl.pc_we  = 1'b1;
        state_d        = FE_RUN;
      end
    end else if (lu_hazard) begin
      // Control-flow in ID is picked up next cycle once the hazard clears
      inc_lu          = 1'b1;
      stall.stall_if  = 1'b1;
      stall.stall_id  = 1'b1;
      stall.bubble_ex = 1'b1;
    end else if (dec_valid && (dec_branch || dec_jump)) begin
      inc_cf          = 1'b1;
      stall.bubble_id = 1'b1;
      state_d         = FE_CF_WAIT;
    end else if (!imem_ready) begin
      inc_imem        = 1'b1;
      stall.stall_if  = 1'b1;
      stall.bubble_id = 1'b1;
    end else if (dec_valid) begin
      fe_ctrl = dec_fe_req;
    end else begin
      fe_ctrl = '{pc_sel: PC_SEL_INC4, pc_we: 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FE_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign stall_if   = stall.stall_if;
  assign stall_id   = stall.stall_id;
  assign stall_ex   = stall.stall_ex;
  assign bubble_id  = stall.bubble_id;
  assign bubble_ex  = stall.bubble_ex;
  assign cf_pending = (state_q == FE_CF_WAIT);

  ama_riscv_sat_cnt #(.CNT_W(CNT_W)) u_cnt_cf (
    .clk (clk),
    .clr (rst),
    .en  (inc_cf),
    .cnt (cnt_cf)
  );

  ama_riscv_sat_cnt #(.CNT_W(CNT_W)) u_cnt_lu (
    .clk (clk),
    .clr (rst),
    .en  (inc_lu),
    .cnt (cnt_lu)
  );

  ama_riscv_sat_cnt #(.CNT_W(CNT_W)) u_cnt_imem (
    .clk (clk),
    .clr (rst),
    .en  (inc_imem),
    .cnt (cnt_imem)
  );

endmodule

// File: tb/tb_ama_riscv_fe_ctrl.sv
// Bench for ama_riscv_fe_ctrl: directed scenarios plus random traffic against
// a cause-priority reference model. Narrow counters make saturation reachable.
module tb_ama_riscv_fe_ctrl;
  import ama_riscv_defines::*;

  localparam int unsigned CNT_W   = 5;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             dec_valid;
  fe_ctrl_t         dec_fe_req;
  logic             dec_branch, dec_jump;
  rf_addr_t         dec_rs1_addr, dec_rs2_addr;
  logic             dec_uses_rs1, dec_uses_rs2;
  logic             ex_load, ex_rd_we;
  rf_addr_t         ex_rd_addr;
  logic             ex_cf_valid, ex_br_taken, ex_jump;
  logic             imem_ready, dmem_busy;
  fe_ctrl_t         fe_ctrl;
  logic             stall_if, stall_id, stall_ex, bubble_id, bubble_ex, cf_pending;
  logic [CNT_W-1:0] cnt_cf, cnt_lu, cnt_imem;

  ama_riscv_fe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .dec_valid    (dec_valid),
    .dec_fe_req   (dec_fe_req),
    .dec_branch   (dec_branch),
    .dec_jump     (dec_jump),
    .dec_rs1_addr (dec_rs1_addr),
    .dec_rs2_addr (dec_rs2_addr),
    .dec_uses_rs1 (dec_uses_rs1),
    .dec_uses_rs2 (dec_uses_rs2),
    .ex_load      (ex_load),
    .ex_rd_we     (ex_rd_we),
    .ex_rd_addr   (ex_rd_addr),
    .ex_cf_valid  (ex_cf_valid),
    .ex_br_taken  (ex_br_taken),
    .ex_jump      (ex_jump),
    .imem_ready   (imem_ready),
    .dmem_busy    (dmem_busy),
    .fe_ctrl      (fe_ctrl),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .stall_ex     (stall_ex),
    .bubble_id    (bubble_id),
    .bubble_ex    (bubble_ex),
    .cf_pending   (cf_pending),
    .cnt_cf       (cnt_cf),
    .cnt_lu       (cnt_lu),
    .cnt_imem     (cnt_imem)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pending-redirect flag and three cycle tallies
  bit m_wait  = 1'b0;
  bit m_known = 1'b0;
  int m_cf    = 0;
  int m_lu    = 0;
  int m_imem  = 0;

  typedef enum int {
    C_RST, C_FREEZE, C_RESOLVE, C_WAITING, C_LU, C_DETECT, C_IMEM, C_PASS
  } cause_e;

  function automatic cause_e classify();
    bit reads_ld;
    reads_ld = (dec_uses_rs1 && dec_rs1_addr == ex_rd_addr) ||
               (dec_uses_rs2 && dec_rs2_addr == ex_rd_addr);
    if (rst) return C_RST;
    if (dmem_busy) return C_FREEZE;
    if (m_wait) return ex_cf_valid ? C_RESOLVE : C_WAITING;
    if (dec_valid && ex_load && ex_rd_we && reads_ld) return C_LU;
    if (dec_valid && (dec_branch || dec_jump)) return C_DETECT;
    if (!imem_ready) return C_IMEM;
    return C_PASS;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Called at a falling edge with inputs applied; checks, advances the model,
  // and returns at the next falling edge.
  task automatic step();
    cause_e     c;
    logic [1:0] e_sel;
    logic       e_we;
    logic [4:0] e_st;  // {stall_if, stall_id, stall_ex, bubble_id, bubble_ex}
    #1;
    c     = classify();
    e_sel = PC_SEL_INC4;
    e_we  = 1'b0;
    e_st  = 5'b00000;
    case (c)
      C_RST:     e_st = 5'b00011;
      C_FREEZE:  e_st = 5'b11100;
      C_RESOLVE: begin
        e_sel = (ex_jump || ex_br_taken) ? PC_SEL_ALU : PC_SEL_INC4;
        e_we  = 1'b1;
        e_st  = 5'b00010;
      end
      C_WAITING: e_st = 5'b00010;
      C_LU:      e_st = 5'b11001;
      C_DETECT:  e_st = 5'b00010;
      C_IMEM:    e_st = 5'b10010;
      C_PASS: begin
        if (dec_valid) {e_sel, e_we} = dec_fe_req;
        else e_we = 1'b1;
      end
      default: e_st = 5'bxxxxx;
    endcase
    check("pc_sel", 64'(fe_ctrl.pc_sel), 64'(e_sel));
    check("pc_we", 64'(fe_ctrl.pc_we), 64'(e_we));
    check("stall_bubble", 64'({stall_if, stall_id, stall_ex, bubble_id, bubble_ex}), 64'(e_st));
    if (m_known) begin
      check("cf_pending", 64'(cf_pending), 64'(m_wait));
      check("cnt_cf", 64'(cnt_cf), 64'(m_cf));
      check("cnt_lu", 64'(cnt_lu), 64'(m_lu));
      check("cnt_imem", 64'(cnt_imem), 64'(m_imem));
    end
    case (c)
      C_RST: begin
        m_wait = 1'b0; m_cf = 0; m_lu = 0; m_imem = 0; m_known = 1'b1;
      end
      C_RESOLVE: begin m_wait = 1'b0; m_cf = sat_inc(m_cf); end
      C_WAITING: m_cf = sat_inc(m_cf);
      C_LU:      m_lu = sat_inc(m_lu);
      C_DETECT:  begin m_wait = 1'b1; m_cf = sat_inc(m_cf); end
      C_IMEM:    m_imem = sat_inc(m_imem);
      default:   ;
    endcase
    @(negedge clk);
  endtask

  task automatic drive_idle();
    rst          = 1'b0;
    dec_valid    = 1'b1;
    dec_fe_req   = '{pc_sel: PC_SEL_INC4, pc_we: 1'b1};
    dec_branch   = 1'b0;
    dec_jump     = 1'b0;
    dec_rs1_addr = 5'd1;
    dec_rs2_addr = 5'd2;
    dec_uses_rs1 = 1'b1;
    dec_uses_rs2 = 1'b1;
    ex_load      = 1'b0;
    ex_rd_we     = 1'b0;
    ex_rd_addr   = 5'd0;
    ex_cf_valid  = 1'b0;
    ex_br_taken  = 1'b0;
    ex_jump      = 1'b0;
    imem_ready   = 1'b1;
    dmem_busy    = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    drive_idle();
    @(negedge clk);
    do_reset();
    check("rst_cf_pending", 64'(cf_pending), 64'd0);
    check("rst_cnt_cf", 64'(cnt_cf), 64'd0);

    // Independent ALU ops: free-running fetch, counters untouched
    for (int i = 0; i < 8; i++) step();
    check("alu_cnt_cf", 64'(cnt_cf), 64'd0);
    check("alu_cnt_lu", 64'(cnt_lu), 64'd0);
    check("alu_cnt_imem", 64'(cnt_imem), 64'd0);

    // lw x5 in EX, add x6,x5,x1 in ID
    do_reset();
    ex_load = 1'b1; ex_rd_we = 1'b1; ex_rd_addr = 5'd5;
    dec_rs1_addr = 5'd5; dec_rs2_addr = 5'd1;
    #1;
    check("lu_pc_we", 64'(fe_ctrl.pc_we), 64'd0);
    check("lu_bubble_ex", 64'(bubble_ex), 64'd1);
    step();
    ex_load = 1'b0; ex_rd_we = 1'b0;
    step();
    check("lu_cnt", 64'(cnt_lu), 64'd1);

    // Taken beq: detect then resolve
    do_reset();
    dec_branch = 1'b1;
    step();
    dec_branch = 1'b0; ex_cf_valid = 1'b1; ex_br_taken = 1'b1;
    #1;
    check("beq_pc_sel", 64'(fe_ctrl.pc_sel), 64'(PC_SEL_ALU));
    step();
    ex_cf_valid = 1'b0; ex_br_taken = 1'b0;
    check("beq_cnt_cf", 64'(cnt_cf), 64'd2);
    check("beq_state", 64'(cf_pending), 64'd0);
    step();

    // Not-taken branch frozen by dmem for 3 cycles
    do_reset();
    dec_branch = 1'b1;
    step();
    dec_branch = 1'b0; ex_cf_valid = 1'b1; dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("frz_cf_pending", 64'(cf_pending), 64'd1);
    dmem_busy = 1'b0;
    step();
    ex_cf_valid = 1'b0;
    check("frz_cnt_cf", 64'(cnt_cf), 64'd2);
    check("frz_state", 64'(cf_pending), 64'd0);

    // imem back-pressure, then run the counter into saturation
    do_reset();
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("imem_cnt4", 64'(cnt_imem), 64'd4);
    for (int i = 0; i < CNT_MAX + 8; i++) step();
    check("imem_sat", 64'(cnt_imem), 64'(CNT_MAX));
    imem_ready = 1'b1;

    // Reset while a redirect is pending
    do_reset();
    dec_jump = 1'b1;
    step();
    dec_jump = 1'b0;
    check("cfw_pending", 64'(cf_pending), 64'd1);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("cfw_rst_pending", 64'(cf_pending), 64'd0);
    check("cfw_rst_cnt_cf", 64'(cnt_cf), 64'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 99) < 2);
      dec_valid    = ($urandom_range(0, 99) < 85);
      dec_fe_req   = fe_ctrl_t'(3'($urandom));
      dec_branch   = ($urandom_range(0, 99) < 15);
      dec_jump     = ($urandom_range(0, 99) < 8);
      dec_rs1_addr = rf_addr_t'($urandom_range(0, 3));
      dec_rs2_addr = rf_addr_t'($urandom_range(0, 3));
      dec_uses_rs1 = 1'($urandom);
      dec_uses_rs2 = 1'($urandom);
      ex_load      = ($urandom_range(0, 99) < 35);
      ex_rd_we     = ($urandom_range(0, 99) < 80);
      ex_rd_addr   = rf_addr_t'($urandom_range(0, 3));
      ex_cf_valid  = ($urandom_range(0, 99) < 50);
      ex_br_taken  = 1'($urandom);
      ex_jump      = ($urandom_range(0, 99) < 30);
      imem_ready   = ($urandom_range(0, 99) < 80);
      dmem_busy    = ($urandom_range(0, 99) < 12);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
